// File: rtl/gerenciador_ataque_pkg.sv
// Shared constants and types for the battleship attack manager.
// Board geometry, lives counter width and the LED status encoding.
package gerenciador_ataque_pkg;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int VIDA_W      = 3;

  typedef logic [NUM_LINHAS-1:0] coluna_t;

  typedef enum logic [1:0] {
    LED_APAGADO,
    LED_ACERTO,
    LED_ERRO
  } estado_led_t;

endpackage

// File: rtl/gerenciador_ataque_if.sv
// Signal bundle between coordinate entry, the attack manager and the LED matrix.
// master = the side producing coordinates/map, slave = the attack manager.
interface gerenciador_ataque_if;
  import gerenciador_ataque_pkg::*;

  logic [2:0]        coordColuna;
  logic [2:0]        coordLinha;
  logic              enable;
  logic              confirmar;
  coluna_t           mapa0, mapa1, mapa2, mapa3, mapa4;
  coluna_t           matriz0, matriz1, matriz2, matriz3, matriz4;
  logic              LED_R;
  logic              LED_G;
  logic              LED_B;
  logic [VIDA_W-1:0] vida;

  modport master (
    output coordColuna, coordLinha, enable, confirmar,
    output mapa0, mapa1, mapa2, mapa3, mapa4,
    input  matriz0, matriz1, matriz2, matriz3, matriz4,
    input  LED_R, LED_G, LED_B, vida
  );

  modport slave (
    input  coordColuna, coordLinha, enable, confirmar,
    input  mapa0, mapa1, mapa2, mapa3, mapa4,
    output matriz0, matriz1, matriz2, matriz3, matriz4,
    output LED_R, LED_G, LED_B, vida
  );

endinterface

// File: rtl/gerenciador_ataque_contador_de_vidas.sv
// Lives counter: reloads on reset or while the game is disabled and
// decrements on request, saturating at zero.
module contador_de_vidas
  import gerenciador_ataque_pkg::*;
#(
  parameter int VIDAS_INICIAIS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              decrementa,
  output logic [VIDA_W-1:0] vida,
  output logic              zero
);

  localparam logic [VIDA_W-1:0] CARGA = VIDA_W'(VIDAS_INICIAIS);

  logic [VIDA_W-1:0] vida_reg;
  logic [VIDA_W-1:0] vida_next;

  always_comb begin
    vida_next = vida_reg;
    if (decrementa && (vida_reg != '0)) begin
      vida_next = vida_reg - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || !enable) begin
      vida_reg <= CARGA;
    end else begin
      vida_reg <= vida_next;
    end
  end

  assign vida = vida_reg;
  assign zero = (vida_reg == '0);

endmodule

// File: rtl/gerenciador_ataque.sv
// Attack manager: keeps the revealed-hits matrix, applies one attack per
// confirmar press against the hidden map, drives status LEDs and lives.
module gerenciador_ataque
  import gerenciador_ataque_pkg::*;
#(
  parameter int VIDAS_INICIAIS = 3
) (
  input  logic clock,
  input  logic reset,
  gerenciador_ataque_if.slave bus
);

  coluna_t              mapa       [NUM_COLUNAS];
  coluna_t              matriz_reg [NUM_COLUNAS];
  coluna_t              candidata  [NUM_COLUNAS];
  logic [NUM_COLUNAS-1:0] difere;
  logic [NUM_COLUNAS-1:0] sel_coluna;

  logic              confirmar_q;
  logic              pulso;
  logic              linha_valida;
  coluna_t           mascara_linha;
  logic              acerto;
  logic              ataque;
  logic              erro;
  logic              ultima_vida;
  logic              sem_vidas;
  logic [VIDA_W-1:0] vida;

  estado_led_t estado_reg;
  estado_led_t estado_next;

  assign mapa[0] = bus.mapa0;
  assign mapa[1] = bus.mapa1;
  assign mapa[2] = bus.mapa2;
  assign mapa[3] = bus.mapa3;
  assign mapa[4] = bus.mapa4;

  always_ff @(posedge clock) begin
    if (!reset || !bus.enable) begin
      confirmar_q <= 1'b0;
    end else begin
      confirmar_q <= bus.confirmar;
    end
  end

  assign pulso = bus.confirmar & ~confirmar_q;

  // Row 7 and columns above 4 select no cell, so such an attack is always a miss.
  assign linha_valida  = (bus.coordLinha != 3'd7);
  assign mascara_linha = linha_valida ? (coluna_t'(1) << bus.coordLinha) : '0;

  generate
    for (genvar gi = 0; gi < NUM_COLUNAS; gi++) begin : g_coluna
      assign sel_coluna[gi] = (bus.coordColuna == 3'(gi));
      assign candidata[gi]  = sel_coluna[gi]
                            ? ((matriz_reg[gi] & ~mascara_linha) | (mapa[gi] & mascara_linha))
                            : matriz_reg[gi];
      assign difere[gi]     = (candidata[gi] != matriz_reg[gi]);
    end
  endgenerate

  assign acerto      = |difere;
  assign ataque      = bus.enable & ~sem_vidas & pulso;
  assign erro        = ataque & ~acerto;
  assign ultima_vida = (vida == 3'd1);

  generate
    for (genvar gi = 0; gi < NUM_COLUNAS; gi++) begin : g_matriz
      always_ff @(posedge clock) begin
        if (!reset || !bus.enable) begin
          matriz_reg[gi] <= '0;
        end else if (ataque) begin
          if (acerto) begin
            matriz_reg[gi] <= candidata[gi];
          end else if (ultima_vida) begin
            matriz_reg[gi] <= '0;
          end
        end
      end
    end
  endgenerate

  contador_de_vidas #(
    .VIDAS_INICIAIS (VIDAS_INICIAIS)
  ) u_contador_de_vidas (
    .clock      (clock),
    .reset      (reset),
    .enable     (bus.enable),
    .decrementa (erro),
    .vida       (vida),
    .zero       (sem_vidas)
  );

  always_ff @(posedge clock) begin
    if (!reset || !bus.enable) begin
      estado_reg <= LED_APAGADO;
    end else begin
      estado_reg <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado_reg;
    if (ataque) begin
      estado_next = acerto ? LED_ACERTO : LED_ERRO;
    end
  end

  assign bus.LED_G   = (estado_reg == LED_ACERTO);
  assign bus.LED_R   = (estado_reg == LED_ERRO);
  assign bus.LED_B   = 1'b0;
  assign bus.vida    = vida;
  assign bus.matriz0 = matriz_reg[0];
  assign bus.matriz1 = matriz_reg[1];
  assign bus.matriz2 = matriz_reg[2];
  assign bus.matriz3 = matriz_reg[3];
  assign bus.matriz4 = matriz_reg[4];

endmodule

// File: tb/tb_gerenciador_ataque.sv
// Bench for gerenciador_ataque: directed game scenario plus random attacks,
// expected states queued by the driver and checked by a separate monitor.
`timescale 1ns/1ps
module tb_gerenciador_ataque;

  localparam int VIDAS = 3;

  logic clock;
  logic reset;

  gerenciador_ataque_if bus ();

  gerenciador_ataque #(
    .VIDAS_INICIAIS (VIDAS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [6:0] mapa_tb [5];
  assign bus.mapa0 = mapa_tb[0];
  assign bus.mapa1 = mapa_tb[1];
  assign bus.mapa2 = mapa_tb[2];
  assign bus.mapa3 = mapa_tb[3];
  assign bus.mapa4 = mapa_tb[4];

  // Reference model: game state as plain cells and integers.
  bit revelado [5][7];
  int vidas;
  int led; // 0 = off, 1 = hit, 2 = miss

  typedef struct {
    string      nome;
    logic [34:0] matriz;
    logic [2:0]  leds; // {R,G,B}
    logic [2:0]  vida;
  } esperado_t;

  esperado_t fila [$];
  int comparacoes = 0;
  int falhas = 0;

  function automatic void modelo_limpa();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        revelado[c][r] = 1'b0;
    vidas = VIDAS;
    led   = 0;
  endfunction

  function automatic void modelo_ataque(int col, int lin);
    if (vidas == 0) return;
    if (col < 5 && lin < 7 && revelado[col][lin] != mapa_tb[col][lin]) begin
      revelado[col][lin] = mapa_tb[col][lin];
      led = 1;
    end else begin
      led = 2;
      vidas = vidas - 1;
      if (vidas == 0)
        for (int c = 0; c < 5; c++)
          for (int r = 0; r < 7; r++)
            revelado[c][r] = 1'b0;
    end
  endfunction

  task automatic push_exp(input string nome);
    esperado_t e;
    e.nome = nome;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        e.matriz[c*7+r] = revelado[c][r];
    e.leds = {(led == 2), (led == 1), 1'b0};
    e.vida = 3'(vidas);
    fila.push_back(e);
  endtask

  always @(negedge clock) begin
    if (fila.size() > 0) begin
      esperado_t e;
      logic [34:0] m;
      logic [2:0]  l;
      e = fila.pop_front();
      m = {bus.matriz4, bus.matriz3, bus.matriz2, bus.matriz1, bus.matriz0};
      l = {bus.LED_R, bus.LED_G, bus.LED_B};
      comparacoes += 3;
      if (m !== e.matriz) begin
        falhas++;
        $display("FAIL %s matriz: got %h required %h", e.nome, m, e.matriz);
      end
      if (l !== e.leds) begin
        falhas++;
        $display("FAIL %s leds RGB: got %b required %b", e.nome, l, e.leds);
      end
      if (bus.vida !== e.vida) begin
        falhas++;
        $display("FAIL %s vida: got %0d required %0d", e.nome, bus.vida, e.vida);
      end
      $display("check %s: matriz=%h leds=%b vida=%0d", e.nome, m, l, bus.vida);
    end
  end

  task automatic reset_op(input string nome);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    modelo_limpa();
    push_exp(nome);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic reabilita(input string nome);
    @(negedge clock);
    bus.enable = 1'b0;
    @(posedge clock);
    #1;
    modelo_limpa();
    push_exp({nome, "_off"});
    @(negedge clock);
    bus.enable = 1'b1;
    @(posedge clock);
    #1;
    push_exp({nome, "_on"});
  endtask

  task automatic atacar(input int col, input int lin, input int hold, input string nome);
    @(negedge clock);
    bus.coordColuna = 3'(col);
    bus.coordLinha  = 3'(lin);
    bus.confirmar   = 1'b1;
    @(posedge clock);
    #1;
    modelo_ataque(col, lin);
    push_exp(nome);
    for (int h = 1; h < hold; h++) begin
      @(negedge clock);
      for (int c = 0; c < 5; c++) mapa_tb[c] = 7'($urandom);
      @(posedge clock);
      #1;
      push_exp({nome, "_hold"});
    end
    @(negedge clock);
    bus.confirmar = 1'b0;
    @(posedge clock);
    #1;
    push_exp({nome, "_solta"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.enable      = 1'b0;
    bus.confirmar   = 1'b0;
    bus.coordColuna = 3'd0;
    bus.coordLinha  = 3'd0;
    mapa_tb[0] = 7'b1110001;
    mapa_tb[1] = 7'b0100000;
    mapa_tb[2] = 7'b0000000;
    mapa_tb[3] = 7'b0000000;
    mapa_tb[4] = 7'b1110000;
    modelo_limpa();

    reset_op("reset");
    @(negedge clock);
    bus.enable = 1'b1;
    @(posedge clock);
    #1;
    push_exp("pos_reset");

    atacar(0, 0, 1, "c0l0_acerto");
    atacar(0, 1, 1, "c0l1_erro");
    atacar(1, 5, 1, "c1l5_acerto");
    mapa_tb[4] = 7'b1110000;
    atacar(4, 6, 5, "c4l6_segurado");
    atacar(0, 0, 1, "c0l0_repetido");
    atacar(5, 0, 1, "c5_fora");
    atacar(0, 0, 1, "pos_fim");
    reabilita("reabilita");

    mapa_tb[0] = 7'b1110001;
    mapa_tb[1] = 7'b0100000;
    mapa_tb[2] = 7'b0000000;
    mapa_tb[3] = 7'b0000000;
    mapa_tb[4] = 7'b1110000;
    atacar(0, 4, 1, "c0l4_acerto");
    atacar(0, 7, 1, "linha7_fora");
    atacar(2, 2, 1, "c2l2_erro");
    atacar(3, 5, 1, "c3l5_ultima");
    atacar(0, 0, 1, "fim_ignorado");
    reabilita("reabilita2");
    atacar(0, 0, 1, "meio_acerto");
    reset_op("reset_meio");

    for (int i = 0; i < 150; i++) begin
      int sel;
      int col;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        reset_op("rnd_reset");
      end else if (sel == 1 || (vidas == 0 && sel < 8)) begin
        reabilita("rnd_enable");
      end else if (sel == 2) begin
        for (int c = 0; c < 5; c++) mapa_tb[c] = 7'($urandom);
      end else begin
        col = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        atacar(col, $urandom_range(0, 7), $urandom_range(1, 3), "rnd_ataque");
      end
    end

    for (int t = 0; t < 10 && fila.size() > 0; t++) @(posedge clock);
    if (fila.size() > 0) begin
      falhas++;
      $display("FAIL fila_pendente: got %0d entries left required 0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparacoes, falhas);
    $finish;
  end

endmodule
